// File: rtl/dcache_sram_pkg.sv
// Shared helpers for dcache_sram: lane parity and NB/AW derivation.
package dcache_sram_pkg;

  localparam int MAX_LANE = 1024;

  function automatic int aw_of(int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int nb_of(int dw, int bw);
    return dw / bw;
  endfunction

  function automatic logic lane_par(logic [MAX_LANE-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// Flop-based single-port data array, lane write enables, 1-cycle read.
// Optional per-lane even parity: define DCACHE_SRAM_PARITY_EN.
module dcache_sram
  import dcache_sram_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 1,
  parameter int BYTE_WIDTH = 8,
  parameter int NUM_WORDS  = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [aw_of(NUM_WORDS)-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [nb_of(DATA_WIDTH, BYTE_WIDTH)-1:0] be_i,
  input  logic [USER_WIDTH-1:0] wuser_i,
`ifdef DCACHE_SRAM_PARITY_EN
  input  logic                  perr_inject_i,
  output logic [nb_of(DATA_WIDTH, BYTE_WIDTH)-1:0] perr_o,
`endif
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [USER_WIDTH-1:0] ruser_o
);

  localparam int AW = aw_of(NUM_WORDS);
  localparam int NB = nb_of(DATA_WIDTH, BYTE_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q  [NUM_WORDS];
  logic [USER_WIDTH-1:0] user_q [NUM_WORDS];
  logic [DATA_WIDTH-1:0] rdata_d, rdata_q;
  logic [USER_WIDTH-1:0] ruser_d, ruser_q;
  logic                  in_range;
  logic                  wr_en;
  logic                  rd_en;

  assign in_range = ({1'b0, addr_i} < (AW+1)'(NUM_WORDS));
  assign wr_en    = req_i & we_i & in_range;
  assign rd_en    = req_i & ~we_i;

  always_comb begin
    rdata_d = rdata_q;
    ruser_d = ruser_q;
    if (rd_en) begin
      rdata_d = in_range ? mem_q[addr_i]  : '0;
      ruser_d = in_range ? user_q[addr_i] : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int w = 0; w < NUM_WORDS; w++) begin
        mem_q[w]  <= '0;
        user_q[w] <= '0;
      end
      rdata_q <= '0;
      ruser_q <= '0;
    end else begin
      if (wr_en) begin
        for (int k = 0; k < NB; k++) begin
          if (be_i[k])
            mem_q[addr_i][k*BYTE_WIDTH +: BYTE_WIDTH] <=
              wdata_i[k*BYTE_WIDTH +: BYTE_WIDTH];
        end
        user_q[addr_i] <= wuser_i;
      end
      rdata_q <= rdata_d;
      ruser_q <= ruser_d;
    end
  end

  assign rdata_o = rdata_q;
  assign ruser_o = ruser_q;

`ifdef DCACHE_SRAM_PARITY_EN
  logic [NB-1:0]       par_q [NUM_WORDS];
  logic [NB-1:0]       wpar;
  logic [NB-1:0]       perr_d, perr_q;
  logic [MAX_LANE-1:0] wext, rext;

  // Stored parity is kept even; inject flips it so reads flag the lane.
  always_comb begin
    wpar   = '0;
    perr_d = perr_q;
    wext   = '0;
    rext   = '0;
    for (int k = 0; k < NB; k++) begin
      wext = '0;
      wext[BYTE_WIDTH-1:0] = wdata_i[k*BYTE_WIDTH +: BYTE_WIDTH];
      wpar[k] = lane_par(wext) ^ perr_inject_i;
    end
    if (rd_en) begin
      perr_d = '0;
      if (in_range) begin
        for (int k = 0; k < NB; k++) begin
          rext = '0;
          rext[BYTE_WIDTH-1:0] = mem_q[addr_i][k*BYTE_WIDTH +: BYTE_WIDTH];
          perr_d[k] = lane_par(rext) ^ par_q[addr_i][k];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int w = 0; w < NUM_WORDS; w++)
        par_q[w] <= '0;
      perr_q <= '0;
    end else begin
      if (wr_en) begin
        for (int k = 0; k < NB; k++) begin
          if (be_i[k])
            par_q[addr_i][k] <= wpar[k];
        end
      end
      perr_q <= perr_d;
    end
  end

  assign perr_o = perr_q;
`endif

endmodule

// File: tb/tb_dcache_sram.sv
// Directed self-checking bench for dcache_sram (64/8 and 8/1 configs).
// Parity checks are included when DCACHE_SRAM_PARITY_EN is defined.
module tb_dcache_sram;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        req = 0, we = 0;
  logic [7:0]  addr = 0;
  logic [63:0] wdata = 0;
  logic [7:0]  be = 0;
  logic        wuser = 0;
  logic [63:0] rdata;
  logic        ruser;

  logic        breq = 0, bwe = 0;
  logic [2:0]  baddr = 0;
  logic [7:0]  bwdata = 0;
  logic [7:0]  bbe = 0;
  logic        bwuser = 0;
  logic [7:0]  brdata;
  logic        bruser;

`ifdef DCACHE_SRAM_PARITY_EN
  logic        inj = 0, binj = 0;
  logic [7:0]  perr;
  logic [7:0]  bperr;
`endif

  dcache_sram #(
    .DATA_WIDTH(64), .USER_WIDTH(1), .BYTE_WIDTH(8), .NUM_WORDS(256)
  ) u_dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we),
    .addr_i(addr), .wdata_i(wdata), .be_i(be), .wuser_i(wuser),
`ifdef DCACHE_SRAM_PARITY_EN
    .perr_inject_i(inj), .perr_o(perr),
`endif
    .rdata_o(rdata), .ruser_o(ruser)
  );

  dcache_sram #(
    .DATA_WIDTH(8), .USER_WIDTH(1), .BYTE_WIDTH(1), .NUM_WORDS(6)
  ) u_bit (
    .clk_i(clk), .rst_i(rst), .req_i(breq), .we_i(bwe),
    .addr_i(baddr), .wdata_i(bwdata), .be_i(bbe), .wuser_i(bwuser),
`ifdef DCACHE_SRAM_PARITY_EN
    .perr_inject_i(binj), .perr_o(bperr),
`endif
    .rdata_o(brdata), .ruser_o(bruser)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [63:0] d,
                    input logic [7:0] b, input logic u, input logic i);
    req = 1; we = 1; addr = a; wdata = d; be = b; wuser = u;
`ifdef DCACHE_SRAM_PARITY_EN
    inj = i;
`endif
    tick();
    req = 0; we = 0;
`ifdef DCACHE_SRAM_PARITY_EN
    inj = 0;
`endif
  endtask

  task automatic rd(input logic [7:0] a);
    req = 1; we = 0; addr = a;
    tick();
    req = 0;
  endtask

  task automatic bwr(input logic [2:0] a, input logic [7:0] d,
                     input logic [7:0] b, input logic u);
    breq = 1; bwe = 1; baddr = a; bwdata = d; bbe = b; bwuser = u;
    tick();
    breq = 0; bwe = 0;
  endtask

  task automatic brd(input logic [2:0] a);
    breq = 1; bwe = 0; baddr = a;
    tick();
    breq = 0;
  endtask

  initial begin
    rst = 1;
    tick(); tick();
    rst = 0;
    chk("rst_rdata", rdata, 64'h0);
    chk("rst_ruser", {63'h0, ruser}, 64'h0);
    chk("rst_brdata", {56'h0, brdata}, 64'h0);
`ifdef DCACHE_SRAM_PARITY_EN
    chk("rst_perr", {56'h0, perr}, 64'h0);
`endif
    rd(8'd5);
    chk("first_rd", rdata, 64'h0);

    wr(8'd5, 64'h0123456789ABCDEF, 8'hFF, 1'b1, 1'b0);
    rd(8'd5);
    chk("wr_rd", rdata, 64'h0123456789ABCDEF);
    chk("wr_rd_user", {63'h0, ruser}, 64'h1);

    wr(8'd5, 64'hFFFFFFFFFFFFFFFF, 8'h0F, 1'b0, 1'b0);
    rd(8'd5);
    chk("partial", rdata, 64'h01234567FFFFFFFF);
    chk("partial_user", {63'h0, ruser}, 64'h0);

    tick();
    chk("hold_idle1", rdata, 64'h01234567FFFFFFFF);
    tick(); tick();
    chk("hold_idle3", rdata, 64'h01234567FFFFFFFF);
    wr(8'd6, 64'hCAFEF00DDEADBEEF, 8'hFF, 1'b1, 1'b0);
    chk("hold_wr", rdata, 64'h01234567FFFFFFFF);
    chk("hold_wr_user", {63'h0, ruser}, 64'h0);
    rd(8'd6);
    chk("b2b", rdata, 64'hCAFEF00DDEADBEEF);

    wr(8'd5, 64'h0, 8'h00, 1'b1, 1'b0);
    rd(8'd5);
    chk("be0_data", rdata, 64'h01234567FFFFFFFF);
    chk("be0_user", {63'h0, ruser}, 64'h1);

    for (int i = 0; i < 4; i++)
      wr(8'(i), 64'h1111111111111111 * (i + 1), 8'hFF, 1'b1, 1'b0);
    rd(8'd3);
    chk("fill3", rdata, 64'h4444444444444444);
    req = 1; we = 1; addr = 8'd0; wdata = 64'hDEAD; be = 8'hFF; wuser = 1;
    rst = 1;
    tick();
    rst = 0; req = 0; we = 0;
    chk("rst_mid_rdata", rdata, 64'h0);
    for (int i = 0; i < 4; i++) begin
      rd(8'(i));
      chk($sformatf("rst_word%0d", i), rdata, 64'h0);
      chk($sformatf("rst_user%0d", i), {63'h0, ruser}, 64'h0);
    end

`ifdef DCACHE_SRAM_PARITY_EN
    wr(8'd9, 64'h01, 8'h01, 1'b0, 1'b1);
    rd(8'd9);
    chk("perr_inj", {56'h0, perr}, 64'h01);
    wr(8'd9, 64'h01, 8'h01, 1'b0, 1'b0);
    rd(8'd9);
    chk("perr_clean", {56'h0, perr}, 64'h00);
`endif

    bwr(3'd2, 8'hFF, 8'hA5, 1'b0);
    brd(3'd2);
    chk("bit_en", {56'h0, brdata}, 64'hA5);
    bwr(3'd2, 8'h00, 8'h00, 1'b1);
    brd(3'd2);
    chk("bit_be0_data", {56'h0, brdata}, 64'hA5);
    chk("bit_be0_user", {63'h0, bruser}, 64'h1);
    bwr(3'd6, 8'h3C, 8'hFF, 1'b1);
    brd(3'd6);
    chk("oor_rd", {56'h0, brdata}, 64'h0);
    chk("oor_user", {63'h0, bruser}, 64'h0);
    brd(3'd2);
    chk("oor_nowr", {56'h0, brdata}, 64'hA5);
    bwr(3'd5, 8'h5A, 8'hFF, 1'b0);
    brd(3'd5);
    chk("top_word", {56'h0, brdata}, 64'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
